// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with per-set LRU, flush and a block-refill port.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_2way #(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  // READ/BUSYWAIT handshake: a fetch is accepted in a cycle where READ is high
  // and BUSYWAIT is low; while BUSYWAIT is high the requester holds ADDR and READ.
  input  logic [ADDR_W-1:0]                           ADDR,
  input  logic                                        READ,
  input  logic                                        FLUSH,
  output logic [31:0]                                 INSTRUCTION,
  output logic                                        BUSYWAIT,
  output logic [ADDR_W-$clog2(BLOCK_WORDS)-3:0]       MEM_ADDR,
  output logic                                        MEM_READ,
  input  logic [32*BLOCK_WORDS-1:0]                   MEM_READDATA,
  input  logic                                        MEM_BUSYWAIT,
  output logic [1:0]                                  DBG_STATE
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                                 HIT_COUNT,
  output logic [31:0]                                 MISS_COUNT
`endif
);

  localparam int WSEL_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // DBG_STATE encoding: 0 = idle, 1 = memory read, 2 = fill
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_FILL     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   valid_d [2];
  logic [SETS-1:0]   lru_q, lru_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_read_q, mem_read_d;
  logic [TAG_W-1:0]  tag_q  [2][SETS];
  logic [31:0]       data_q [2][SETS][BLOCK_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              match0, match1, hit, hit_way, victim;
  logic              flush_now, fill_we, miss_start;
  logic              unused_addr_bits;

  assign idx  = ADDR[OFF_W+IDX_W-1:OFF_W];
  assign tag  = ADDR[ADDR_W-1:OFF_W+IDX_W];
  assign wsel = ADDR[OFF_W-1:2];
  assign unused_addr_bits = ^ADDR[1:0];

  assign match0  = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign match1  = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = READ && (match0 || match1);
  assign hit_way = !match0;

  // Fill an empty way first so a set never holds the same tag twice.
  assign victim = !valid_q[0][idx] ? 1'b0 :
                  !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign flush_now  = (state_q == S_IDLE) && (FLUSH || flush_pend_q);
  assign fill_we    = (state_q == S_FILL);
  assign miss_start = (state_q == S_IDLE) && !flush_now && READ && !hit;

  always_comb begin
    state_d      = state_q;
    valid_d[0]   = valid_q[0];
    valid_d[1]   = valid_q[1];
    lru_d        = lru_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      S_IDLE: begin
        if (flush_now) begin
          valid_d[0]   = '0;
          valid_d[1]   = '0;
          lru_d        = '0;
          flush_pend_d = 1'b0;
        end else if (hit) begin
          lru_d[idx] = ~hit_way;
        end else if (READ) begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (FLUSH) flush_pend_d = 1'b1;
        if (!MEM_BUSYWAIT) state_d = S_FILL;
      end
      S_FILL: begin
        if (FLUSH) flush_pend_d = 1'b1;
        valid_d[victim][idx] = 1'b1;
        lru_d[idx]           = ~victim;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    mem_read_d = (state_d == S_MEM_READ);
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q[0]   <= valid_d[0];
      valid_q[1]   <= valid_d[1];
      lru_q        <= lru_d;
      flush_pend_q <= flush_pend_d;
      mem_read_q   <= mem_read_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(negedge CLK) begin
    if (fill_we) begin
      tag_q[victim][idx] <= tag;
      for (int w = 0; w < BLOCK_WORDS; w++) begin
        data_q[victim][idx][w] <= MEM_READDATA[32*w +: 32];
      end
    end
  end

  always_comb begin
    BUSYWAIT = 1'b1;
    if (state_q == S_IDLE) BUSYWAIT = (READ && !hit) || flush_now;
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDR    = (state_q == S_MEM_READ) ? ADDR[ADDR_W-1:OFF_W] : '0;
  assign INSTRUCTION = hit ? data_q[hit_way][idx][wsel] : NOP;
  assign DBG_STATE   = state_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, (state_q == S_IDLE) && hit};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_start};
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: directed scenarios plus random fetches checked against
// an LRU-list model of the cache and a functional backing memory.
module tb_icache_2way;
  localparam int SETS = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  ADDR;
  logic         READ;
  logic         FLUSH;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic [27:0]  MEM_ADDR;
  logic         MEM_READ;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [1:0]   DBG_STATE;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  icache_2way dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .READ(READ), .FLUSH(FLUSH),
    .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .MEM_ADDR(MEM_ADDR),
    .MEM_READ(MEM_READ), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .DBG_STATE(DBG_STATE)
`ifdef ICACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- bookkeeping ----------------
  logic [39:0] exp_q[$];   // {expected stall cycles, expected word}
  logic [39:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int target = 0;
  int cur_fmode = 0;
  int mem_lat = 0;
  int mem_cnt = 0;

  // Reference model: per set, most- and least-recently used block addresses.
  logic [27:0] mru_blk [SETS];
  logic [27:0] old_blk [SETS];
  int          nvalid  [SETS];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input int w);
    if (blk == 28'd4 && w == 0) return 32'hDEAD_BEEF;
    return ({4'd0, blk} * 32'h9E37_79B1) ^ (32'(w) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) nvalid[s] = 0;
  endfunction

  // Returns 1 on hit; on a miss the block becomes MRU and the LRU entry is dropped.
  function automatic bit model_access(input logic [27:0] blk);
    int s;
    s = int'(blk % SETS);
    if (nvalid[s] > 0 && mru_blk[s] == blk) return 1'b1;
    if (nvalid[s] == 2 && old_blk[s] == blk) begin
      old_blk[s] = mru_blk[s];
      mru_blk[s] = blk;
      return 1'b1;
    end
    old_blk[s] = mru_blk[s];
    mru_blk[s] = blk;
    if (nvalid[s] < 2) nvalid[s]++;
    return 1'b0;
  endfunction

  // ---------------- backing memory ----------------
  always begin
    @(posedge CLK);
    if (MEM_READ) begin
      if (mem_cnt < mem_lat) begin
        MEM_BUSYWAIT = 1'b1;
        mem_cnt++;
        MEM_READDATA = {4{$urandom()}};
      end else begin
        MEM_BUSYWAIT = 1'b0;
        for (int w = 0; w < 4; w++) MEM_READDATA[32*w +: 32] = mem_word(MEM_ADDR, w);
      end
    end else begin
      MEM_BUSYWAIT = 1'b1;
      mem_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(posedge CLK);
    #2;
    if (RESET) begin
      stall_cnt = 0;
    end else if (READ) begin
      if (BUSYWAIT) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got %h expected none", INSTRUCTION);
        end else begin
          mon_exp = exp_q.pop_front();
          check("instruction", INSTRUCTION, mon_exp[31:0]);
          check("stall_cycles", 32'(stall_cnt), {24'd0, mon_exp[39:32]});
        end
        stall_cnt = 0;
        done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // fmode: 0 plain fetch, 1 FLUSH with the request, 2 FLUSH while memory is read.
  task automatic start_fetch(input logic [31:0] addr, input int lat, input int fmode);
    logic [27:0] blk;
    int stall;
    bit hit;
    blk = addr[31:4];
    @(posedge CLK);
    ADDR = addr;
    READ = 1'b1;
    mem_lat = lat;
    FLUSH = (fmode == 1);
    if (fmode == 1) begin
      model_flush();
      void'(model_access(blk));
      stall = 1 + lat + 3;
    end else begin
      hit = model_access(blk);
      if (hit) stall = 0;
      else if (fmode == 2) begin
        model_flush();
        void'(model_access(blk));
        stall = 2 * (lat + 3) + 1;
      end else stall = lat + 3;
    end
    exp_q.push_back({stall[7:0], mem_word(blk, int'(addr[3:2]))});
    cur_fmode = fmode;
    target = done_cnt + 1;
  endtask

  task automatic finish_fetch();
    bit flushed;
    int c;
    flushed = 1'b0;
    c = 0;
    while (done_cnt < target && c < 200) begin
      @(posedge CLK);
      c++;
      FLUSH = 1'b0;
      if (cur_fmode == 2 && !flushed && MEM_READ) begin
        FLUSH = 1'b1;
        flushed = 1'b1;
      end
    end
    if (done_cnt < target) begin
      check("fetch_timeout", 32'(done_cnt), 32'(target));
      exp_q.delete();
    end
    READ = 1'b0;
    FLUSH = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input int lat, input int fmode);
    start_fetch(addr, lat, fmode);
    finish_fetch();
  endtask

  task automatic idle_flush();
    @(posedge CLK);
    READ = 1'b0;
    FLUSH = 1'b1;
    #2;
    check("flush_busywait", {31'd0, BUSYWAIT}, 32'd1);
    @(posedge CLK);
    FLUSH = 1'b0;
    model_flush();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    int r;
    logic [27:0] blk;
    logic [31:0] a;
    RESET = 1'b1;
    READ = 1'b1;
    FLUSH = 1'b0;
    ADDR = 32'h40;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    model_flush();
    repeat (2) @(posedge CLK);
    #2;
    check("reset_busywait_read1", {31'd0, BUSYWAIT}, 32'd1);
    check("reset_instruction", INSTRUCTION, NOP);
    check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("reset_mem_addr", {4'd0, MEM_ADDR}, 32'd0);
    check("reset_state", {30'd0, DBG_STATE}, 32'd0);
    READ = 1'b0;
    #1;
    check("reset_busywait_read0", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK);
    RESET = 1'b0;

    // First miss on 0x40 with three busy memory cycles.
    start_fetch(32'h40, 3, 0);
    #2;
    check("miss_busywait", {31'd0, BUSYWAIT}, 32'd1);
    check("miss_instruction_nop", INSTRUCTION, NOP);
    @(posedge CLK);
    #2;
    check("memread_asserted", {31'd0, MEM_READ}, 32'd1);
    check("memread_addr", {4'd0, MEM_ADDR}, 32'h4);
    check("memread_state", {30'd0, DBG_STATE}, 32'd1);
    finish_fetch();

    // Same-set traffic: LRU eviction of the older block.
    fetch(32'h140, 1, 0);
    fetch(32'h040, 0, 0);
    fetch(32'h240, 2, 0);
    fetch(32'h040, 0, 0);
    fetch(32'h140, 0, 0);

    // All words of one block.
    fetch(32'h40, 0, 0);
    for (int w = 0; w < 4; w++) fetch(32'h40 + 32'(w * 4), 0, 0);

    // Flush in idle, then the cached block misses again.
    idle_flush();
    fetch(32'h40, 1, 0);

    // Flush raised during memory read, and flush raised with a request.
    fetch(32'h300, 2, 2);
    fetch(32'h300, 0, 0);
    fetch(32'h300, 1, 1);

    // Reset in the middle of a miss.
    start_fetch(32'h5000, 5, 0);
    c = 0;
    while (!MEM_READ && c < 20) begin
      @(posedge CLK);
      c++;
    end
    #3;
    RESET = 1'b1;
    #1;
    check("midreset_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("midreset_state", {30'd0, DBG_STATE}, 32'd0);
    check("midreset_busywait", {31'd0, BUSYWAIT}, 32'd1);
    check("midreset_instruction", INSTRUCTION, NOP);
    exp_q.delete();
    model_flush();
    @(posedge CLK);
    READ = 1'b0;
    @(posedge CLK);
    RESET = 1'b0;
`ifdef ICACHE_STATS_EN
    check("stats_hit_reset", HIT_COUNT, 32'd0);
    check("stats_miss_reset", MISS_COUNT, 32'd0);
    // The miss itself completes with one hit cycle, then two more hits.
    fetch(32'h40, 1, 0);
    fetch(32'h44, 0, 0);
    fetch(32'h48, 0, 0);
    @(posedge CLK);
    #2;
    check("stats_miss_count", MISS_COUNT, 32'd1);
    check("stats_hit_count", HIT_COUNT, 32'd3);
`endif
    fetch(32'h40, 0, 0);

    // Random traffic over a small footprint so sets fill and evict often.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        idle_flush();
      end else begin
        blk = 28'($urandom_range(0, 23));
        if ($urandom_range(0, 3) == 0) blk = blk + 28'h010_0000;
        a = {blk, 4'b0000} | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        fetch(a, int'($urandom_range(0, 3)), (r == 1) ? 1 : (r == 2) ? 2 : 0);
      end
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    repeat (3) @(posedge CLK);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
